// File: rtl/mineral_sprite_drawer_pkg.sv
// rtl/mineral_sprite_drawer_pkg.sv - shared states, screen limits and mineral colours
package mineral_sprite_drawer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_LOAD,
      S_DRAW,
      S_DONE,
      S_HOLD
   } state_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam int X_W     = 8;
   localparam int Y_W     = 7;
   localparam int COUNT_W = 8;

   localparam logic [2:0] COLOUR_GOLD    = 3'b110;
   localparam logic [2:0] COLOUR_STONE   = 3'b111;
   localparam logic [2:0] COLOUR_DIAMOND = 3'b011;

endpackage

// File: rtl/mineral_sprite_drawer_if.sv
// rtl/mineral_sprite_drawer_if.sv - request/pixel bundle between view FSM, drawer and VGA adapter
interface mineral_sprite_drawer_if;
   import mineral_sprite_drawer_pkg::*;

   logic               enable_random;
   logic               enable_draw;
   logic               resetn_count;
   logic               draw_done;
   logic [COUNT_W-1:0] obj_count;
   logic [X_W-1:0]     x_out;
   logic [Y_W-1:0]     y_out;
   logic [2:0]         colour_out;
   logic               plot;

   modport master (
      output enable_random, enable_draw, resetn_count,
      input  draw_done, obj_count, x_out, y_out, colour_out, plot
   );

   modport slave (
      input  enable_random, enable_draw, resetn_count,
      output draw_done, obj_count, x_out, y_out, colour_out, plot
   );

endinterface

// File: rtl/mineral_sprite_drawer_lfsr16.sv
// rtl/mineral_sprite_drawer_lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [15:0] q
);

   logic [15:0] r_q;

   always_ff @(posedge clk) begin
      if (!resetn) r_q <= SEED;
      else         r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
   end

   assign q = r_q;

endmodule

// File: rtl/mineral_sprite_drawer.sv
// rtl/mineral_sprite_drawer.sv - rasters one solid sprite per request from a random position table
module mineral_sprite_drawer
   import mineral_sprite_drawer_pkg::*;
#(
   parameter int          MAX_OBJ  = 4,
   parameter int          SPRITE_W = 8,
   parameter int          SPRITE_H = 8,
   parameter int          X_MIN    = 8,
   parameter int          Y_MIN    = 40,
   parameter logic [2:0]  COLOUR   = COLOUR_GOLD,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input logic                    clk,
   input logic                    resetn,
   mineral_sprite_drawer_if.slave bus
);

   localparam int IDX_W = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;
   localparam int DX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int DY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_OBJ - 1);
   localparam logic [DX_W-1:0]  DX_MAX   = DX_W'(SPRITE_W - 1);
   localparam logic [DY_W-1:0]  DY_MAX   = DY_W'(SPRITE_H - 1);

   state_t             r_state, w_next;
   logic [15:0]        w_lfsr;
   logic               w_unused_lfsr;
   logic [IDX_W-1:0]   r_fill_idx, w_idx;
   logic [X_W-1:0]     r_tab_x [MAX_OBJ];
   logic [Y_W-1:0]     r_tab_y [MAX_OBJ];
   logic [X_W-1:0]     r_base_x, r_x;
   logic [Y_W-1:0]     r_base_y, r_y;
   logic [DX_W-1:0]    r_dx, w_ndx;
   logic [DY_W-1:0]    r_dy, w_ndy;
   logic [COUNT_W-1:0] r_count;
   logic [2:0]         r_colour;
   logic               r_plot;
   logic               w_overflow, w_last_px, w_last_fill;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .q      (w_lfsr)
   );

   // Only bits [6:0] and [13:8] feed positions.
   assign w_unused_lfsr = &{1'b0, w_lfsr[15:14], w_lfsr[7]};
   assign w_idx         = r_count[IDX_W-1:0];

   always_comb begin
      w_next      = r_state;
      w_overflow  = (r_count >= COUNT_W'(MAX_OBJ));
      w_last_fill = (r_fill_idx == LAST_IDX);
      w_last_px   = (r_dx == DX_MAX) && (r_dy == DY_MAX);
      w_ndx       = (r_dx == DX_MAX) ? '0 : r_dx + DX_W'(1);
      w_ndy       = (r_dx == DX_MAX) ? r_dy + DY_W'(1) : r_dy;
      case (r_state)
         S_IDLE: begin
            if (bus.enable_random)    w_next = S_FILL;
            else if (bus.enable_draw) w_next = S_LOAD;
         end
         S_FILL: if (w_last_fill) w_next = S_IDLE;
         S_LOAD: w_next = w_overflow ? S_DONE : S_DRAW;
         S_DRAW: if (w_last_px) w_next = S_DONE;
         S_DONE: w_next = S_HOLD;
         S_HOLD: if (!bus.enable_draw) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_fill_idx <= '0;
         r_base_x   <= '0;
         r_base_y   <= '0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_count    <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_colour   <= '0;
         r_plot     <= 1'b0;
         for (int i = 0; i < MAX_OBJ; i++) begin
            r_tab_x[i] <= '0;
            r_tab_y[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (r_state == S_FILL) begin
            r_tab_x[r_fill_idx] <= X_W'(X_MIN) + X_W'(w_lfsr[6:0]);
            r_tab_y[r_fill_idx] <= Y_W'(Y_MIN) + Y_W'(w_lfsr[13:8]);
            r_fill_idx          <= w_last_fill ? '0 : r_fill_idx + IDX_W'(1);
         end
         // Output registers are loaded one edge early so pixel 0 is visible in the first DRAW cycle.
         if (r_state == S_LOAD && !w_overflow) begin
            r_base_x <= r_tab_x[w_idx];
            r_base_y <= r_tab_y[w_idx];
            r_dx     <= '0;
            r_dy     <= '0;
            r_x      <= r_tab_x[w_idx];
            r_y      <= r_tab_y[w_idx];
            r_colour <= COLOUR;
            r_plot   <= 1'b1;
         end else if (r_state == S_DRAW) begin
            if (w_last_px) begin
               r_plot   <= 1'b0;
               r_colour <= '0;
            end else begin
               r_dx <= w_ndx;
               r_dy <= w_ndy;
               r_x  <= r_base_x + X_W'(w_ndx);
               r_y  <= r_base_y + Y_W'(w_ndy);
            end
         end
         if (!bus.resetn_count)
            r_count <= '0;
         else if (r_state == S_DONE && r_count != '1)
            r_count <= r_count + COUNT_W'(1);
      end
   end

   assign bus.draw_done  = (r_state == S_DONE);
   assign bus.obj_count  = r_count;
   assign bus.x_out      = r_x;
   assign bus.y_out      = r_y;
   assign bus.colour_out = r_colour;
   assign bus.plot       = r_plot;

endmodule

// File: tb/tb_mineral_sprite_drawer.sv
// tb/tb_mineral_sprite_drawer.sv - randomized bench with a behavioural position/raster model
module tb_mineral_sprite_drawer;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          NOBJ = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   mineral_sprite_drawer_if bus();

   mineral_sprite_drawer dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] m_lfsr;
   logic [7:0]  m_x [NOBJ];
   logic [6:0]  m_y [NOBJ];
   int          m_count;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference LFSR: feedback is the parity of the tapped bits 16,14,13,11.
   always @(posedge clk) begin
      if (!resetn) m_lfsr <= SEED;
      else         m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   end

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NOBJ; i++) begin
         m_x[i] = '0;
         m_y[i] = '0;
      end
      m_count = 0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 7)) @(negedge clk);
   endtask

   task automatic do_fill();
      bus.enable_random = 1'b1;
      @(negedge clk);
      bus.enable_random = 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
         m_x[i] = 8'd8 + {1'b0, m_lfsr[6:0]};
         m_y[i] = 7'd40 + {1'b0, m_lfsr[13:8]};
         if (i == 1) bus.enable_random = 1'b1;
         if (i == 2) bus.enable_random = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_draw(input bit clear_at_done, input int drop_at);
      int idx, plots, done_c, exp_done, exp_px;
      bit ovf;
      logic [7:0] ex;
      logic [6:0] ey;
      ovf      = (m_count >= NOBJ);
      idx      = m_count % NOBJ;
      exp_done = ovf ? 2 : 66;
      plots    = 0;
      done_c   = -1;
      bus.enable_draw = 1'b1;
      for (int c = 1; c <= 80 && done_c < 0; c++) begin
         @(negedge clk);
         if (bus.plot) begin
            ex = m_x[idx] + 8'(plots % 8);
            ey = m_y[idx] + 7'(plots / 8);
            exp_px = (int'(ex) << 10) | (int'(ey) << 3) | 6;
            check_value("pixel", int'({bus.x_out, bus.y_out, bus.colour_out}), exp_px);
            plots++;
         end
         if (bus.draw_done) begin
            done_c = c;
            if (clear_at_done) bus.resetn_count = 1'b0;
         end
         if (c == drop_at) bus.enable_draw = 1'b0;
      end
      check_value("done_cycle", done_c, exp_done);
      check_value("plot_count", plots, ovf ? 0 : 64);
      if (clear_at_done) m_count = 0;
      else if (m_count < 255) m_count++;
      @(negedge clk);
      bus.resetn_count = 1'b1;
      check_value("done_width", int'(bus.draw_done), 0);
      check_value("obj_count", int'(bus.obj_count), m_count);
      check_value("idle_colour", int'(bus.colour_out), 0);
      if (bus.enable_draw) begin
         repeat (3) begin
            @(negedge clk);
            check_value("hold_no_plot", int'(bus.plot), 0);
         end
         bus.enable_draw = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_count();
      bus.resetn_count = 1'b0;
      @(negedge clk);
      bus.resetn_count = 1'b1;
      m_count = 0;
      check_value("count_clear", int'(bus.obj_count), 0);
   endtask

   task automatic mid_reset();
      bus.enable_draw = 1'b1;
      repeat (22) @(negedge clk);
      check_value("pixel20_plot", int'(bus.plot), 1);
      resetn = 1'b0;
      @(negedge clk);
      check_value("rst_plot", int'(bus.plot), 0);
      check_value("rst_done", int'(bus.draw_done), 0);
      check_value("rst_count", int'(bus.obj_count), 0);
      check_value("rst_colour", int'(bus.colour_out), 0);
      bus.enable_draw = 1'b0;
      @(negedge clk);
      check_value("rst_done2", int'(bus.draw_done), 0);
      resetn = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   function automatic int rand_drop();
      return ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 60)) : 0;
   endfunction

   initial begin
      bus.enable_random = 1'b0;
      bus.enable_draw   = 1'b0;
      bus.resetn_count  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_value("reset_plot", int'(bus.plot), 0);
      end
      check_value("reset_x", int'(bus.x_out), 0);
      check_value("reset_y", int'(bus.y_out), 0);
      check_value("reset_colour", int'(bus.colour_out), 0);
      check_value("reset_count", int'(bus.obj_count), 0);
      check_value("reset_done", int'(bus.draw_done), 0);
      resetn = 1'b1;
      model_clear();

      gap();
      do_fill();
      for (int i = 0; i < 5; i++) begin
         gap();
         run_draw(1'b0, (i == 0) ? 0 : rand_drop());
      end
      clear_count();
      run_draw(1'b0, 0);
      run_draw(1'b1, 0);
      run_draw(1'b0, rand_drop());

      gap();
      do_fill();
      run_draw(1'b0, rand_drop());
      run_draw(1'b0, 0);

      mid_reset();
      run_draw(1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
